// File: rtl/wb_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_pkg
// Shared definitions for the round-robin Wishbone arbiter:
//   - Wishbone bus widths (address, data, byte select)
//   - arbiter state encoding (IDLE/BUSY/ERR)
//   - watchdog timer width helper
// -----------------------------------------------------------------------------
package wb_rr_arbiter_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_ERR  = 2'b10
  } arb_state_t;

  // The watchdog counter must hold 0..timeout. A disabled watchdog (timeout 0)
  // still gets a 1-bit register so the declaration stays legal. That register
  // is held at zero.
  function automatic int timer_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_if
// Bundle of every Wishbone signal around the arbiter. The master-side bus is
// m_* with N masters packed side by side. The slave-side bus is s_*.
// Suffixes _i/_o are relative to the arbiter.
//   modport slave  : arbiter view. It is the slave of the masters and drives
//                    the downstream slave request.
//   modport master : environment view. It covers the masters plus the
//                    downstream slave.
// Handshake: classic Wishbone B4. A request is live while CYC and STB are
// high. It completes in the cycle where ACK (or ERR) is seen high. The
// arbiter never registers ACK, so a beat takes exactly as many cycles as the
// slave needs.
// -----------------------------------------------------------------------------
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import wb_rr_arbiter_pkg::*;

  logic [NUM_MASTERS-1:0]          m_cyc_i;
  logic [NUM_MASTERS-1:0]          m_stb_i;
  logic [NUM_MASTERS-1:0]          m_we_i;
  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i;
  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i;
  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i;
  logic [WB_DAT_W-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]          m_ack_o;
  logic [NUM_MASTERS-1:0]          m_err_o;

  logic                            s_cyc_o;
  logic                            s_stb_o;
  logic                            s_we_o;
  logic [WB_SEL_W-1:0]             s_sel_o;
  logic [WB_ADR_W-1:0]             s_adr_o;
  logic [WB_DAT_W-1:0]             s_dat_o;
  logic [WB_DAT_W-1:0]             s_dat_i;
  logic                            s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );

endinterface

// File: rtl/wb_rr_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker. It scans the requests starting at
// i_ptr+1 (mod N) and returns the first requester, both one-hot and as an
// index. It is kept free of Wishbone detail so other schedulers can reuse it.
// Ports:
//   i_req   [N]     request vector
//   i_ptr   [PTR_W] last winner. The scan starts just after it.
//   o_gnt   [N]     one-hot winner, zero if nothing requests
//   o_idx   [PTR_W] winner index, zero if nothing requests
//   o_valid         at least one request present
// -----------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    int idx;
    idx     = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(i_ptr) + i) % N;
      if (!o_valid && i_req[idx]) begin
        o_valid    = 1'b1;
        o_gnt[idx] = 1'b1;
        o_idx      = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin Wishbone B4 classic arbiter. It shares one slave port among
// NUM_MASTERS masters. A master owns the slave for its whole CYC. A watchdog
// ends a stalled beat with a one-cycle ERR after TIMEOUT_CYCLES stall cycles.
// A TIMEOUT_CYCLES value of 0 disables the watchdog.
// Ports:
//   wb_clk_i      clock
//   wb_rstn_i     asynchronous active-low reset
//   wb            bus bundle (wb_rr_arbiter_if.slave)
//   gnt_o   [N]   registered one-hot grant, zero while idle
//   timeout_o     one-cycle pulse when the watchdog fires
//   o_dbg_state   current arbiter state
// -----------------------------------------------------------------------------
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rstn_i,
  wb_rr_arbiter_if.slave         wb,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic                   timeout_o,
  output arb_state_t             o_dbg_state
);

  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam int TMR_W = timer_width(TIMEOUT_CYCLES);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TMR_W-1:0] TMR_FIRE = WDOG_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [PTR_W-1:0]       r_ptr;
  logic [TMR_W-1:0]       r_timer;

  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [PTR_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;

  logic                   w_cyc_g, w_stb_g, w_we_g;
  logic [WB_SEL_W-1:0]    w_sel_g;
  logic [WB_ADR_W-1:0]    w_adr_g;
  logic [WB_DAT_W-1:0]    w_dat_g;
  logic                   w_busy, w_stall, w_ack_fwd, w_timeout;

  rr_priority_pick #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req   (wb.m_cyc_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // AND-OR mux. The grant is one-hot or zero, so the OR-reduction selects at
  // most one master. With no grant, every field reads back as zero.
  always_comb begin
    w_cyc_g = 1'b0;
    w_stb_g = 1'b0;
    w_we_g  = 1'b0;
    w_sel_g = '0;
    w_adr_g = '0;
    w_dat_g = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_cyc_g = w_cyc_g | (r_gnt[k] & wb.m_cyc_i[k]);
      w_stb_g = w_stb_g | (r_gnt[k] & wb.m_stb_i[k]);
      w_we_g  = w_we_g  | (r_gnt[k] & wb.m_we_i[k]);
      w_sel_g = w_sel_g | ({WB_SEL_W{r_gnt[k]}} & wb.m_sel_i[WB_SEL_W*k +: WB_SEL_W]);
      w_adr_g = w_adr_g | ({WB_ADR_W{r_gnt[k]}} & wb.m_adr_i[WB_ADR_W*k +: WB_ADR_W]);
      w_dat_g = w_dat_g | ({WB_DAT_W{r_gnt[k]}} & wb.m_dat_i[WB_DAT_W*k +: WB_DAT_W]);
    end
  end

  // The slave request is gated by state. While in ERR, and in the cycle the
  // owner drops CYC, the slave sees nothing. Any ACK it returns then is
  // discarded.
  assign w_busy     = (r_state == ST_BUSY);
  assign wb.s_cyc_o = w_busy & w_cyc_g;
  assign wb.s_stb_o = w_busy & w_cyc_g & w_stb_g;
  assign wb.s_we_o  = w_busy & w_we_g;
  assign wb.s_sel_o = w_sel_g;
  assign wb.s_adr_o = w_adr_g;
  assign wb.s_dat_o = w_dat_g;

  assign w_stall   = wb.s_stb_o & ~wb.s_ack_i;
  assign w_ack_fwd = wb.s_stb_o & wb.s_ack_i;
  // The ACK-wins rule follows from w_stall: an ACK in the firing cycle
  // suppresses the timeout.
  assign w_timeout = WDOG_EN && w_stall && (r_timer == TMR_FIRE);

  assign wb.m_dat_o  = wb.s_dat_i;
  assign wb.m_ack_o  = r_gnt & {NUM_MASTERS{w_ack_fwd}};
  assign wb.m_err_o  = r_gnt & {NUM_MASTERS{w_timeout}};
  assign timeout_o   = w_timeout;
  assign gnt_o       = r_gnt;
  assign o_dbg_state = r_state;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= PTR_W'(NUM_MASTERS - 1);
      r_timer <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_pick_valid) begin
            r_gnt   <= w_pick_gnt;
            r_ptr   <= w_pick_idx;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!w_cyc_g) begin
            r_gnt   <= '0;
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_timer <= '0;
            r_state <= ST_ERR;
          end else if (WDOG_EN && w_stall) begin
            // Saturating count. It stays at TMR_MAX rather than wrapping.
            if (r_timer != TMR_MAX) r_timer <= r_timer + TMR_W'(1);
          end else begin
            r_timer <= '0;
          end
        end
        ST_ERR: begin
          r_timer <= '0;
          if (!w_cyc_g) begin
            r_gnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
